mc_controller: RTL and testbench

- Multi-cycle control FSM for the 16-bit accumulator processor.
- Sits directly upstream of the processor datapath and drives every datapath control strobe and ALU function select.
- Takes the 3-bit opcode from the datapath instruction register.
- Sequences fetch, decode, memory access, execute and branch cycles. Also provides a halt flag, a state debug output and a retired-instruction counter.

---
 rtl/mc_controller.sv | 148 ++++++++++++++
 tb/tb_mc_controller.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/mc_controller.sv
// rtl/mc_controller.sv - multi-cycle control FSM for the 16-bit accumulator processor
module mc_controller #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic [2:0]       opcode,
  output logic             PCWriteCond,
  output logic             PCWrite,
  output logic             IorD,
  output logic             memRead,
  output logic             memWrite,
  output logic             IRWrite,
  output logic             memToAcc,
  output logic             accWrite,
  output logic             ALUSrcA,
  output logic             ALUSrcB,
  output logic             PCSrc,
  output logic [1:0]       ALUFunc,
  output logic             halted,
  output logic [3:0]       state_dbg,
  output logic [CNT_W-1:0] instr_count
);

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_FETCH    = 4'd1,
    S_DECODE   = 4'd2,
    S_MEM_RD   = 4'd3,
    S_LOAD_ACC = 4'd4,
    S_EXEC     = 4'd5,
    S_MEM_WR   = 4'd6,
    S_JMP      = 4'd7,
    S_JZ       = 4'd8,
    S_HALT     = 4'd9
  } state_t;

  localparam logic [2:0] OP_LDA = 3'b000;
  localparam logic [2:0] OP_STA = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b011;
  localparam logic [2:0] OP_AND = 3'b100;
  localparam logic [2:0] OP_JMP = 3'b101;
  localparam logic [2:0] OP_JZ  = 3'b110;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           r_state;
  logic [CNT_W-1:0] r_count;
  state_t           w_end_next;

  // Instruction-final states all return the same way: continue if run, else park.
  assign w_end_next = run ? S_FETCH : S_IDLE;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_count <= '0;
    end else begin
      case (r_state)
        S_IDLE:   r_state <= run ? S_FETCH : S_IDLE;
        S_FETCH:  r_state <= S_DECODE;
        S_DECODE: begin
          case (opcode)
            OP_LDA, OP_ADD, OP_SUB, OP_AND: r_state <= S_MEM_RD;
            OP_STA:                         r_state <= S_MEM_WR;
            OP_JMP:                         r_state <= S_JMP;
            OP_JZ:                          r_state <= S_JZ;
            default:                        r_state <= S_HALT;
          endcase
          if (r_count != '1)
            r_count <= r_count + CNT_ONE;
        end
        S_MEM_RD:   r_state <= (opcode == OP_LDA) ? S_LOAD_ACC : S_EXEC;
        S_LOAD_ACC: r_state <= w_end_next;
        S_EXEC:     r_state <= w_end_next;
        S_MEM_WR:   r_state <= w_end_next;
        S_JMP:      r_state <= w_end_next;
        S_JZ:       r_state <= w_end_next;
        S_HALT:     r_state <= S_HALT;
        default:    r_state <= S_IDLE;
      endcase
    end
  end

  // Strobes decode straight from the state register so an async reset clears them at once.
  always_comb begin
    PCWriteCond = 1'b0;
    PCWrite     = 1'b0;
    IorD        = 1'b0;
    memRead     = 1'b0;
    memWrite    = 1'b0;
    IRWrite     = 1'b0;
    memToAcc    = 1'b0;
    accWrite    = 1'b0;
    ALUSrcA     = 1'b0;
    ALUSrcB     = 1'b0;
    PCSrc       = 1'b0;
    ALUFunc     = 2'b00;
    halted      = 1'b0;
    case (r_state)
      S_FETCH: begin
        memRead = 1'b1;
        IRWrite = 1'b1;
        ALUSrcB = 1'b1;
        PCWrite = 1'b1;
      end
      S_MEM_RD: begin
        IorD    = 1'b1;
        memRead = 1'b1;
      end
      S_LOAD_ACC: begin
        memToAcc = 1'b1;
        accWrite = 1'b1;
      end
      S_EXEC: begin
        ALUSrcA  = 1'b1;
        accWrite = 1'b1;
        case (opcode)
          OP_SUB:  ALUFunc = 2'b01;
          OP_AND:  ALUFunc = 2'b10;
          default: ALUFunc = 2'b00;
        endcase
      end
      S_MEM_WR: begin
        IorD     = 1'b1;
        memWrite = 1'b1;
      end
      S_JMP: begin
        PCSrc   = 1'b1;
        PCWrite = 1'b1;
      end
      S_JZ: begin
        ALUSrcA     = 1'b1;
        ALUFunc     = 2'b11;
        PCSrc       = 1'b1;
        PCWriteCond = 1'b1;
      end
      S_HALT:  halted = 1'b1;
      default: ;
    endcase
  end

  assign state_dbg   = r_state;
  assign instr_count = r_count;

endmodule

// File: tb/tb_mc_controller.sv
// tb/tb_mc_controller.sv - self-checking bench for mc_controller
module tb_mc_controller;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        run = 1'b0;
  logic [2:0]  opcode = 3'd0;

  logic        PCWriteCond, PCWrite, IorD, memRead, memWrite, IRWrite;
  logic        memToAcc, accWrite, ALUSrcA, ALUSrcB, PCSrc, halted;
  logic [1:0]  ALUFunc;
  logic [3:0]  state_dbg;
  logic [15:0] instr_count;

  logic        s_PCWriteCond, s_PCWrite, s_IorD, s_memRead, s_memWrite, s_IRWrite;
  logic        s_memToAcc, s_accWrite, s_ALUSrcA, s_ALUSrcB, s_PCSrc, s_halted;
  logic [1:0]  s_ALUFunc;
  logic [3:0]  s_state_dbg;
  logic [1:0]  s_instr_count;

  mc_controller #(.CNT_W(16)) u_dut (
    .clk(clk), .rst(rst), .run(run), .opcode(opcode),
    .PCWriteCond(PCWriteCond), .PCWrite(PCWrite), .IorD(IorD), .memRead(memRead),
    .memWrite(memWrite), .IRWrite(IRWrite), .memToAcc(memToAcc), .accWrite(accWrite),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .PCSrc(PCSrc), .ALUFunc(ALUFunc),
    .halted(halted), .state_dbg(state_dbg), .instr_count(instr_count)
  );

  mc_controller #(.CNT_W(2)) u_sat (
    .clk(clk), .rst(rst), .run(run), .opcode(opcode),
    .PCWriteCond(s_PCWriteCond), .PCWrite(s_PCWrite), .IorD(s_IorD), .memRead(s_memRead),
    .memWrite(s_memWrite), .IRWrite(s_IRWrite), .memToAcc(s_memToAcc), .accWrite(s_accWrite),
    .ALUSrcA(s_ALUSrcA), .ALUSrcB(s_ALUSrcB), .PCSrc(s_PCSrc), .ALUFunc(s_ALUFunc),
    .halted(s_halted), .state_dbg(s_state_dbg), .instr_count(s_instr_count)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int m_state = 0;
  int m_cnt = 0;
  int m_cnt_sat = 0;

  logic [12:0] w_strb;
  assign w_strb = {PCWriteCond, PCWrite, IorD, memRead, memWrite, IRWrite,
                   memToAcc, accWrite, ALUSrcA, ALUSrcB, PCSrc, ALUFunc};

  function automatic logic [12:0] exp_strb(int st, logic [2:0] op);
    logic pcwc, pcw, iord, mr, mw, irw, m2a, aw, sa, sb, pcs;
    logic [1:0] f;
    {pcwc, pcw, iord, mr, mw, irw, m2a, aw, sa, sb, pcs} = '0;
    f = 2'b00;
    case (st)
      1: begin mr = 1; irw = 1; sb = 1; pcw = 1; end
      3: begin iord = 1; mr = 1; end
      4: begin m2a = 1; aw = 1; end
      5: begin
        sa = 1; aw = 1;
        if (op == 3'b011) f = 2'b01;
        else if (op == 3'b100) f = 2'b10;
      end
      6: begin iord = 1; mw = 1; end
      7: begin pcs = 1; pcw = 1; end
      8: begin sa = 1; f = 2'b11; pcs = 1; pcwc = 1; end
      default: ;
    endcase
    return {pcwc, pcw, iord, mr, mw, irw, m2a, aw, sa, sb, pcs, f};
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_now(int st);
    chk("state", state_dbg, st);
    chk("strobes", w_strb, exp_strb(st, opcode));
    chk("halted", halted, (st == 9) ? 1 : 0);
    chk("count", instr_count, m_cnt);
    chk("sat_count", s_instr_count, m_cnt_sat);
    chk("rw_excl", memRead & memWrite, 0);
  endtask

  task automatic step(int st);
    @(posedge clk);
    #1;
    if (m_state == 2) begin
      if (m_cnt < 65535) m_cnt++;
      if (m_cnt_sat < 3) m_cnt_sat++;
    end
    m_state = st;
    check_now(st);
  endtask

  // States visited after FETCH for each opcode, straight from the instruction definitions.
  function automatic void op_path(logic [2:0] op, ref int q[$]);
    q.delete();
    q.push_back(2);
    case (op)
      3'd0:             begin q.push_back(3); q.push_back(4); end
      3'd1:             q.push_back(6);
      3'd2, 3'd3, 3'd4: begin q.push_back(3); q.push_back(5); end
      3'd5:             q.push_back(7);
      3'd6:             q.push_back(8);
      default:          q.push_back(9);
    endcase
  endfunction

  task automatic do_instr(logic [2:0] op, logic next_run);
    int q[$];
    opcode = op;
    op_path(op, q);
    foreach (q[i]) step(q[i]);
    if (op != 3'd7) begin
      run = next_run;
      step(next_run ? 1 : 0);
    end
  endtask

  task automatic model_reset();
    m_state = 0;
    m_cnt = 0;
    m_cnt_sat = 0;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check_now(0);
    rst = 1'b1;
    repeat (5) step(0);
    run = 1'b1;
    step(1);

    do_instr(3'd2, 1'b1);
    do_instr(3'd0, 1'b1);
    do_instr(3'd1, 1'b1);
    do_instr(3'd6, 1'b1);
    do_instr(3'd5, 1'b1);

    for (int n = 0; n < 40; n++) begin
      logic [2:0] op;
      logic nr;
      op = 3'($urandom_range(0, 6));
      nr = ($urandom_range(0, 3) != 0);
      do_instr(op, nr);
      if (!nr) begin
        repeat ($urandom_range(1, 3)) step(0);
        run = 1'b1;
        step(1);
      end
    end

    do_instr(3'd7, 1'b1);
    for (int n = 0; n < 20; n++) begin
      run = 1'($urandom_range(0, 1));
      step(9);
    end

    #2 rst = 1'b0;
    #1;
    model_reset();
    check_now(0);
    run = 1'b1;
    opcode = 3'd2;
    @(posedge clk);
    #1;
    check_now(0);
    rst = 1'b1;
    step(1);

    opcode = 3'd2;
    step(2);
    step(3);
    #2 rst = 1'b0;
    #1;
    model_reset();
    check_now(0);
    @(posedge clk);
    #1;
    check_now(0);
    rst = 1'b1;
    step(1);

    repeat (5) do_instr(3'd2, 1'b1);
    chk("sat_final", s_instr_count, 3);
    chk("cnt_final", instr_count, 5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
